inst_mem_arbiter: RTL and testbench
===================================

Name: inst_mem_arbiter

Overview:
Shares the single-ported instruction memory between two requesters: the CPU fetch stage (IF) and the debug/program-loader port (DBG).
- The memory has one read port plus a write path, and registered read data valid one cycle after the chip enable.
- The arbiter grants one requester per cycle and steers the returning read data back to its owner.
- It raises a stall request to the pipeline controller when fetch is blocked.
- A starvation counter bounds how long DBG can lock out fetch.

Parameters:
ADDR_W, 32, byte address width of both requester ports and the memory port.
DATA_W, 32, instruction word width.
MAX_DBG_BURST, 4, maximum consecutive DBG grants while IF is waiting; range 1..15.

Ports:
clk  in  1  system clock, all state on rising edge.
rst  in  1  asynchronous reset, active-low (0 = reset).
if_req  in  1  fetch request.
if_addr  in  ADDR_W  fetch byte address.
if_flush  in  1  discard the IF response currently in flight (branch/exception).
if_gnt  out  1  fetch accepted this cycle.
if_rvalid  out  1  fetch data valid.
if_rdata  out  DATA_W  fetched instruction.
dbg_req  in  1  debug/loader request.
dbg_we  in  1  1 = write, 0 = read.
dbg_addr  in  ADDR_W  debug byte address.
dbg_wdata  in  DATA_W  debug write data.
dbg_gnt  out  1  debug access accepted this cycle.
dbg_rvalid  out  1  debug response (read data or write ack).
dbg_rdata  out  DATA_W  debug read data; ZeroWord on write ack.
stallreq  out  1  to pipeline ctrl: fetch blocked this cycle.
mem_ce  out  1  memory chip enable (ChipEnable/ChipDisable encoding).
mem_we  out  1  memory write enable.
mem_addr  out  ADDR_W  memory byte address; memory indexes the word via addr[..:2].
mem_wdata  out  DATA_W  memory write data.
mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_ce.

Behaviour:
- Reset (rst=0, async):
  - state=ST_IDLE, burst_cnt=0, resp_owner=OWN_NONE.
  - All registered outputs 0: if_rvalid, dbg_rvalid, if_rdata, dbg_rdata = ZeroWord.
  - While rst=0, all grant and memory outputs are forced to 0: mem_ce=ChipDisable, mem_we=0, if_gnt=0, dbg_gnt=0, stallreq=0.
- Arbitration is combinational on the current inputs and registered state, decided every cycle:
  - starve = if_req && (burst_cnt == MAX_DBG_BURST).
  - If dbg_req && !starve, grant DBG.
  - Else if if_req, grant IF.
  - Else no grant, mem_ce=ChipDisable.
- Memory drive when granted:
  - mem_ce=ChipEnable.
  - mem_addr and mem_wdata come from the winner.
  - mem_we = dbg_we when DBG wins, else 0.
  - When there is no grant, mem_addr and mem_wdata are 0.
- stallreq = if_req && !if_gnt, combinational.
- burst_cnt (registered):
  - +1 on a DBG grant while if_req=1, saturating at MAX_DBG_BURST.
  - Cleared on any IF grant, or on any cycle with if_req=0.
- State register records the last winner: ST_IDLE, ST_IF or ST_DBG. It is used for the response tag and debug visibility; priority does not depend on it.
- Response pipeline, latency 1:
  - On a grant, resp_owner <= winner, with a write flag for DBG.
  - Next cycle:
    - Owner IF: if_rvalid=1, if_rdata=mem_rdata.
    - Owner DBG read: dbg_rvalid=1, dbg_rdata=mem_rdata.
    - Owner DBG write: dbg_rvalid=1, dbg_rdata=ZeroWord.
  - The rvalid of the non-owner is 0; rdata holds its last value.
  - Each rvalid is a single-cycle pulse.
- if_flush:
  - Asserted in the cycle a fetch response would be returned, it suppresses if_rvalid for that response.
  - Asserted together with a new if_req, it does not block that new grant; the new fetch proceeds normally.
- Back-to-back grants: one access per cycle, fully pipelined; alternating owners need no bubble.
- Simultaneous if_req and dbg_req at burst_cnt<MAX: DBG wins and stallreq=1.
- Reset mid-operation: the in-flight response is dropped; no rvalid follows reset release.
- Addresses pass through unmodified; alignment is the requester's responsibility.

Decomposition:
- Shared defines include (existing defines file) gets:
  - Owner encodings OWN_NONE, OWN_IF, OWN_DBG.
  - State encodings ST_IDLE, ST_IF, ST_DBG.
  - A `define for the default MAX_DBG_BURST.
- Reuse the existing ZeroWord, ChipEnable and ChipDisable definitions.
- Single module, no sub-module: the burst counter and response tag are small enough inline.

Test Plan:
- Reset/idle: hold rst=0 with random requests, then release with no requests -> all outputs 0, mem_ce=ChipDisable, no rvalid for 5 cycles.
- IF-only stream: if_req=1 with addresses 0x0, 0x4, 0x8, memory preloaded 0x34010001/0x34020002/0x34030003 -> if_gnt=1 each cycle, if_rvalid the following cycles carrying those words in order, stallreq=0.
- DBG write then IF read: dbg write 0xDEADBEEF to 0x10, next cycle if_req at 0x10 -> dbg_rvalid with dbg_rdata=0, then if_rdata=0xDEADBEEF.
- Starvation bound: dbg_req and if_req held continuously, MAX_DBG_BURST=4 -> grant pattern DBG×4, IF×1, repeating; stallreq=1 exactly on the DBG cycles.
- Flush: IF granted at 0x20, if_flush=1 the next cycle -> no if_rvalid for 0x20; a new if_req at 0x40 that cycle returns valid data the cycle after.
- Async reset mid-access: assert rst=0 between a DBG read grant and its response -> dbg_rvalid never pulses, outputs zero immediately without waiting for a clock edge.

Source files
------------

// File: rtl/inst_mem_arbiter_pkg.sv
// Shared encodings for the instruction-memory arbiter: owner tags, FSM
// states, the memory chip-enable levels and the all-zero data word.

`ifndef INST_MEM_ARB_MAX_DBG_BURST
`define INST_MEM_ARB_MAX_DBG_BURST 4
`endif

package inst_mem_arbiter_pkg;

  // Data word returned on a write acknowledge and used as the reset value
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;

  // Memory chip-enable levels
  localparam logic        ChipEnable  = 1'b1;
  localparam logic        ChipDisable = 1'b0;

  // Who owns the response that comes back next cycle
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DBG  = 2'd2
  } owner_e;

  // Last winner of the memory port
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_IF   = 2'd1,
    ST_DBG  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/inst_mem_arbiter.sv
// Arbiter sharing the single-ported instruction memory between the fetch
// stage (IF) and the debug/program-loader port (DBG). DBG has priority,
// bounded by a burst counter so fetch is never locked out indefinitely.
// Read data returns one cycle after the grant and is steered to its owner.
//
// Handshake: a requester holds req (plus address/data) until it sees gnt
// in the same cycle; req && gnt is the one accepted transfer. Exactly one
// cycle later the owner sees a single-cycle rvalid pulse with its data
// (a DBG write gets rvalid with zero data as its acknowledge). There is no
// back-pressure on the response side.

module inst_mem_arbiter
  import inst_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_DBG_BURST = `INST_MEM_ARB_MAX_DBG_BURST
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,

  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,

  output logic              stallreq,

  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic [1:0]        arb_state
);

  localparam logic [3:0]        MAX_BURST = 4'(MAX_DBG_BURST);
  localparam logic [DATA_W-1:0] ZERO_DATA = DATA_W'(ZeroWord);

  arb_state_e        state_q, state_d;
  logic [3:0]        burst_cnt, burst_d;
  owner_e            resp_owner;
  logic              resp_wr;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dbg_rdata_q;
  logic              starve;
  logic              if_resp_live;
  logic              dbg_resp_live;

  // State, burst counter and response tag registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      burst_cnt  <= 4'd0;
      resp_owner <= OWN_NONE;
      resp_wr    <= 1'b0;
    end else begin
      state_q    <= state_d;
      burst_cnt  <= burst_d;
      resp_wr    <= dbg_gnt && dbg_we;
      if (dbg_gnt)     resp_owner <= OWN_DBG;
      else if (if_gnt) resp_owner <= OWN_IF;
      else             resp_owner <= OWN_NONE;
    end
  end

  // Arbitration, memory drive and next-state; everything forced idle in reset
  always_comb begin
    state_d   = state_q;
    starve    = if_req && (burst_cnt == MAX_BURST);
    if_gnt    = 1'b0;
    dbg_gnt   = 1'b0;
    mem_ce    = ChipDisable;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    stallreq  = 1'b0;
    if (rst) begin
      if (dbg_req && !starve) begin
        dbg_gnt   = 1'b1;
        mem_ce    = ChipEnable;
        mem_we    = dbg_we;
        mem_addr  = dbg_addr;
        mem_wdata = dbg_wdata;
        state_d   = ST_DBG;
      end else if (if_req) begin
        if_gnt    = 1'b1;
        mem_ce    = ChipEnable;
        mem_addr  = if_addr;
        state_d   = ST_IF;
      end
      stallreq = if_req && !if_gnt;
    end
  end

  // Burst counter: counts DBG wins while fetch waits, resets once fetch is
  // served or stops asking
  always_comb begin
    burst_d = burst_cnt;
    if (!if_req || if_gnt) begin
      burst_d = 4'd0;
    end else if (dbg_gnt && (burst_cnt < MAX_BURST)) begin
      burst_d = burst_cnt + 4'd1;
    end
  end

  // Response steering: owner sees live memory data, others hold last value
  always_comb begin
    if_resp_live  = (resp_owner == OWN_IF) && !if_flush;
    dbg_resp_live = (resp_owner == OWN_DBG);
    if_rvalid     = if_resp_live;
    dbg_rvalid    = dbg_resp_live;
    if_rdata      = if_resp_live ? mem_rdata : if_rdata_q;
    if (dbg_resp_live) dbg_rdata = resp_wr ? ZERO_DATA : mem_rdata;
    else               dbg_rdata = dbg_rdata_q;
  end

  // Capture delivered data so rdata holds between responses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rdata_q  <= ZERO_DATA;
      dbg_rdata_q <= ZERO_DATA;
    end else begin
      if (if_resp_live)  if_rdata_q  <= mem_rdata;
      if (dbg_resp_live) dbg_rdata_q <= resp_wr ? ZERO_DATA : mem_rdata;
    end
  end

  assign arb_state = state_q;

endmodule

// File: tb/tb_inst_mem_arbiter.sv
// Testbench for inst_mem_arbiter: a registered-read memory model behind
// the DUT, per-feature tasks with inline checks, and a response monitor
// popping expected data/cycle pairs from per-requester queues.

module tb_inst_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MAXB   = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic              if_req, if_flush, if_gnt, if_rvalid;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata, dbg_rdata;
  logic              stallreq, mem_ce, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [1:0]        arb_state;

  inst_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_DBG_BURST(MAXB)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
    .dbg_rdata(dbg_rdata), .stallreq(stallreq),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .arb_state(arb_state)
  );

  // ---------------- memory behind the DUT ----------------
  logic [DATA_W-1:0] mem [256];
  logic [DATA_W-1:0] model_mem [256];

  always @(posedge clk) begin
    if (mem_ce) begin
      if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[9:2]];
    end
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [DATA_W-1:0] if_exp_q[$];
  int                if_cyc_q[$];
  logic [DATA_W-1:0] dbg_exp_q[$];
  int                dbg_cyc_q[$];

  // Response monitor: every rvalid must match the oldest expectation
  always @(negedge clk) begin
    logic [DATA_W-1:0] e;
    int ec;
    if (rst) begin
      if (if_rvalid) begin
        n_cmp++;
        if (if_exp_q.size() == 0) begin
          n_err++;
          $display("FAIL if_resp: unexpected rvalid data=%h cyc=%0d, required none", if_rdata, cyc);
        end else begin
          e = if_exp_q.pop_front();
          ec = if_cyc_q.pop_front();
          if (if_rdata !== e || cyc != ec) begin
            n_err++;
            $display("FAIL if_resp: got data=%h cyc=%0d, required data=%h cyc=%0d", if_rdata, cyc, e, ec);
          end
        end
      end
      if (dbg_rvalid) begin
        n_cmp++;
        if (dbg_exp_q.size() == 0) begin
          n_err++;
          $display("FAIL dbg_resp: unexpected rvalid data=%h cyc=%0d, required none", dbg_rdata, cyc);
        end else begin
          e = dbg_exp_q.pop_front();
          ec = dbg_cyc_q.pop_front();
          if (dbg_rdata !== e || cyc != ec) begin
            n_err++;
            $display("FAIL dbg_resp: got data=%h cyc=%0d, required data=%h cyc=%0d", dbg_rdata, cyc, e, ec);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
  endtask

  task automatic preload();
    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'h0; model_mem[i] = 32'h0;
    end
    mem[0] = 32'h3401_0001;  model_mem[0] = 32'h3401_0001;
    mem[1] = 32'h3402_0002;  model_mem[1] = 32'h3402_0002;
    mem[2] = 32'h3403_0003;  model_mem[2] = 32'h3403_0003;
    mem[3] = 32'h3404_0004;  model_mem[3] = 32'h3404_0004;
    mem[8] = 32'h1111_2222;  model_mem[8] = 32'h1111_2222;
    mem[16] = 32'h5555_6666; model_mem[16] = 32'h5555_6666;
  endtask

  task automatic expect_if(input logic [ADDR_W-1:0] a);
    if_exp_q.push_back(model_mem[a[9:2]]);
    if_cyc_q.push_back(cyc + 1);
  endtask

  task automatic expect_dbg(input logic [DATA_W-1:0] d);
    dbg_exp_q.push_back(d);
    dbg_cyc_q.push_back(cyc + 1);
  endtask

  task automatic check_grants(input string name, input logic eif, input logic edbg,
                              input logic estall);
    n_cmp++;
    if (if_gnt !== eif || dbg_gnt !== edbg || stallreq !== estall) begin
      n_err++;
      $display("FAIL %s: got if_gnt=%b dbg_gnt=%b stallreq=%b, required %b %b %b",
               name, if_gnt, dbg_gnt, stallreq, eif, edbg, estall);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if_req = 1'($urandom_range(1)); dbg_req = 1'($urandom_range(1));
      dbg_we = 1'($urandom_range(1));
      if_addr = $urandom_range(255) << 2; dbg_addr = $urandom_range(255) << 2;
      @(negedge clk);
      n_cmp++;
      if (if_gnt !== 1'b0 || dbg_gnt !== 1'b0 || mem_ce !== 1'b0 || mem_we !== 1'b0 ||
          stallreq !== 1'b0 || if_rvalid !== 1'b0 || dbg_rvalid !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold: gnt=%b%b ce=%b we=%b stall=%b rv=%b%b, required all 0",
                 if_gnt, dbg_gnt, mem_ce, mem_we, stallreq, if_rvalid, dbg_rvalid);
      end
      next_cycle();
    end
    idle_inputs();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (mem_ce !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0 || if_rvalid !== 1'b0 ||
          dbg_rvalid !== 1'b0 || if_rdata !== '0 || dbg_rdata !== '0 || stallreq !== 1'b0 ||
          arb_state !== 2'd0) begin
        n_err++;
        $display("FAIL reset_idle: ce=%b addr=%h rv=%b%b ird=%h drd=%h stall=%b st=%0d, required all 0",
                 mem_ce, mem_addr, if_rvalid, dbg_rvalid, if_rdata, dbg_rdata, stallreq, arb_state);
      end
      next_cycle();
    end
  endtask

  task automatic test_if_stream();
    for (int i = 0; i < 3; i++) begin
      if_req = 1'b1; if_addr = 32'(i * 4);
      expect_if(if_addr);
      @(negedge clk);
      check_grants("if_stream_gnt", 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (mem_ce !== 1'b1 || mem_we !== 1'b0 || mem_addr !== if_addr) begin
        n_err++;
        $display("FAIL if_stream_mem: got ce=%b we=%b addr=%h, required 1 0 %h",
                 mem_ce, mem_we, mem_addr, if_addr);
      end
      next_cycle();
    end
    idle_inputs();
    repeat (2) next_cycle();
  endtask

  task automatic test_dbg_write_then_if();
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h10; dbg_wdata = 32'hDEAD_BEEF;
    model_mem[4] = 32'hDEAD_BEEF;
    expect_dbg(32'h0);
    @(negedge clk);
    check_grants("dbg_write_gnt", 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (mem_we !== 1'b1 || mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h10) begin
      n_err++;
      $display("FAIL dbg_write_mem: got we=%b wdata=%h addr=%h, required 1 deadbeef 10",
               mem_we, mem_wdata, mem_addr);
    end
    next_cycle();
    idle_inputs();
    if_req = 1'b1; if_addr = 32'h10;
    expect_if(if_addr);
    @(negedge clk);
    check_grants("if_after_write_gnt", 1'b1, 1'b0, 1'b0);
    next_cycle();
    idle_inputs();
    repeat (2) next_cycle();
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] addrs [4];
    addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8; addrs[3] = 32'h10;
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      if (i % 2 == 0) begin
        if_req = 1'b1; if_addr = addrs[i]; expect_if(addrs[i]);
      end else begin
        dbg_req = 1'b1; dbg_addr = addrs[i]; expect_dbg(model_mem[addrs[i][9:2]]);
      end
      @(negedge clk);
      check_grants("b2b_gnt", (i % 2 == 0), (i % 2 == 1), 1'b0);
      next_cycle();
    end
    idle_inputs();
    repeat (2) next_cycle();
  endtask

  task automatic test_starvation();
    if_req = 1'b1; if_addr = 32'h0;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h8;
    for (int k = 0; k < 3 * (MAXB + 1); k++) begin
      if (k % (MAXB + 1) < MAXB) expect_dbg(model_mem[2]);
      else                       expect_if(32'h0);
      @(negedge clk);
      if (k % (MAXB + 1) < MAXB) check_grants("starve_dbg_phase", 1'b0, 1'b1, 1'b1);
      else                       check_grants("starve_if_phase", 1'b1, 1'b0, 1'b0);
      next_cycle();
    end
    idle_inputs();
    repeat (2) next_cycle();
  endtask

  task automatic test_flush();
    if_req = 1'b1; if_addr = 32'h20;
    @(negedge clk);
    check_grants("flush_first_gnt", 1'b1, 1'b0, 1'b0);
    next_cycle();
    if_addr = 32'h40; if_flush = 1'b1;
    expect_if(if_addr);
    @(negedge clk);
    check_grants("flush_new_gnt", 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (if_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_suppress: got if_rvalid=%b, required 0", if_rvalid);
    end
    next_cycle();
    idle_inputs();
    repeat (2) next_cycle();
  endtask

  task automatic test_async_reset();
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'hC;
    @(negedge clk);
    check_grants("areset_pre_gnt", 1'b0, 1'b1, 1'b0);
    #1;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (dbg_gnt !== 1'b0 || mem_ce !== 1'b0 || mem_addr !== '0 || dbg_rvalid !== 1'b0 ||
        dbg_rdata !== '0 || if_rdata !== '0) begin
      n_err++;
      $display("FAIL areset_immediate: got gnt=%b ce=%b addr=%h rv=%b drd=%h ird=%h, required all 0",
               dbg_gnt, mem_ce, mem_addr, dbg_rvalid, dbg_rdata, if_rdata);
    end
    next_cycle();
    next_cycle();
    idle_inputs();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (dbg_rvalid !== 1'b0 || if_rvalid !== 1'b0) begin
        n_err++;
        $display("FAIL areset_no_resp: got rvalid if=%b dbg=%b, required 0 0", if_rvalid, dbg_rvalid);
      end
      next_cycle();
    end
  endtask

  // Watchdog bound on the whole run
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    preload();
    test_reset();
    test_if_stream();
    test_dbg_write_then_if();
    test_back_to_back();
    test_starvation();
    test_flush();
    test_async_reset();
    n_cmp++;
    if (if_exp_q.size() != 0 || dbg_exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got pending if=%0d dbg=%0d, required 0 0", if_exp_q.size(), dbg_exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
